// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - Two-stage pipelined carry look-ahead adder/subtractor with valid/ready handshake
//
// Purpose: WIDTH-bit A+B+ci or A-B built from 4-bit look-ahead groups. The low
// half is resolved in stage 1, the upper half plus flags in stage 2. Results
// leave two cycles after acceptance, strictly in order, with stalls absorbed
// in the pipeline registers.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake (in_ready independent of in_valid)
//   a, b, sub, ci         operands; sub=1 selects A-B and ignores ci
//   out_valid, out_ready  output handshake
//   sum, co, ovf          result, carry out of MSB (no-borrow for sub), signed overflow
//   zero, neg             sum == 0, sum MSB
module cla_adder_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int H = WIDTH / 2;

    // Ripples a chain of 4-bit look-ahead groups across one half-word.
    // Returns {carry_out, sum}. Propagate uses OR, which is exact for carries;
    // the sum bits use XOR of the operands.
    function automatic logic [H:0] cla_half(
        input logic [H-1:0] x,
        input logic [H-1:0] y,
        input logic         cin
    );
        logic [H-1:0] s;
        logic [3:0]   g;
        logic [3:0]   p;
        logic         c0;
        logic         c1;
        logic         c2;
        logic         c3;
        logic         c4;
        s  = '0;
        c0 = cin;
        for (int k = 0; k < H / 4; k++) begin
            g  = x[4*k +: 4] & y[4*k +: 4];
            p  = x[4*k +: 4] | y[4*k +: 4];
            c1 = g[0] | (p[0] & c0);
            c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
            c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
            c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0);
            s[4*k +: 4] = x[4*k +: 4] ^ y[4*k +: 4] ^ {c3, c2, c1, c0};
            c0 = c4;
        end
        return {c0, s};
    endfunction

    logic             s1_valid;
    logic [H-1:0]     s1_sum_lo;
    logic             s1_hc;
    logic [H-1:0]     s1_a_hi;
    logic [H-1:0]     s1_bb_hi;

    logic             s2_free;
    logic             s1_advance;
    logic             accept;

    logic [WIDTH-1:0] bb;
    logic             cin;
    logic [H:0]       lo_res;
    logic [H:0]       hi_res;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;

    assign s2_free    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_free;
    assign in_ready   = !s1_valid || s2_free;
    assign accept     = in_valid && in_ready;

    assign bb  = sub ? ~b : b;
    assign cin = sub ? 1'b1 : ci;

    assign lo_res   = cla_half(a[H-1:0], bb[H-1:0], cin);
    assign hi_res   = cla_half(s1_a_hi, s1_bb_hi, s1_hc);
    assign sum_next = {hi_res[H-1:0], s1_sum_lo};
    assign ovf_next = (s1_a_hi[H-1] == s1_bb_hi[H-1]) && (hi_res[H-1] != s1_a_hi[H-1]);

    // Stage 1: low half resolved, upper-half operands held for stage 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_sum_lo <= '0;
            s1_hc     <= 1'b0;
            s1_a_hi   <= '0;
            s1_bb_hi  <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_sum_lo <= lo_res[H-1:0];
            s1_hc     <= lo_res[H];
            s1_a_hi   <= a[WIDTH-1:H];
            s1_bb_hi  <= bb[WIDTH-1:H];
        end else if (s1_advance) begin
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2: output register. Data only changes when a new result enters,
    // so it stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            sum       <= sum_next;
            co        <= hi_res[H];
            ovf       <= ovf_next;
            zero      <= (sum_next == '0);
            neg       <= sum_next[WIDTH-1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
